// File: rtl/clock_pkg.sv
// ---------------------------------------------------------------------------
// clock_pkg
//  Shared definitions for the multi-alarm time-of-day clock: default widths
//  and moduli, the counter type and the per-channel alarm state encoding.
// ---------------------------------------------------------------------------
package clock_pkg;

    localparam int DEF_CNT_W       = 17;
    localparam int DEF_DAY_SECONDS = 86400;
    localparam int DEF_SNOOZE_SEC  = 540;

    typedef logic [DEF_CNT_W-1:0] counter_t;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ARMED   = 2'd1,
        RINGING = 2'd2,
        SNOOZED = 2'd3
    } alarm_st_e;

endpackage

// File: rtl/alarm_channel.sv
// ---------------------------------------------------------------------------
// alarm_channel
//  One alarm channel: state machine, setpoint and snooze deadline.
//  Ports:
//   clock, reset_n      system clock, async active-low reset
//   wr, wr_time, wr_en  decoded write strobe, setpoint and enable
//   ack, snooze         broadcast dismiss / snooze pulses
//   tick, counter       registered second tick and the counter value it produced
//   ring                registered: 1 while RINGING
//   ring_nxt            next-cycle value of ring (lets the top register OR)
// ---------------------------------------------------------------------------
module alarm_channel
    import clock_pkg::*;
#(
    parameter int CNT_W       = DEF_CNT_W,
    parameter int DAY_SECONDS = DEF_DAY_SECONDS,
    parameter int SNOOZE_SEC  = DEF_SNOOZE_SEC
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             wr,
    input  logic [CNT_W-1:0] wr_time,
    input  logic             wr_en,
    input  logic             ack,
    input  logic             snooze,
    input  logic             tick,
    input  logic [CNT_W-1:0] counter,
    output logic             ring,
    output logic             ring_nxt
);

    localparam logic [CNT_W:0] DAY_EXT    = (CNT_W+1)'(DAY_SECONDS);
    localparam logic [CNT_W:0] SNOOZE_EXT = (CNT_W+1)'(SNOOZE_SEC);

    alarm_st_e        state_r, state_nxt_s;
    logic [CNT_W-1:0] setpoint_r, setpoint_nxt_s;
    logic [CNT_W-1:0] deadline_r, deadline_nxt_s;
    logic [CNT_W-1:0] target_s, snz_dl_s;
    logic [CNT_W:0]   sum_s;
    logic             match_s;
    logic             ring_r;

    // Next-state, setpoint and deadline selection with wr > ack > snooze > match
    always_comb begin
        state_nxt_s    = state_r;
        setpoint_nxt_s = setpoint_r;
        deadline_nxt_s = deadline_r;
        target_s       = (state_r == SNOOZED) ? deadline_r : setpoint_r;
        match_s        = tick && (counter == target_s);
        // one extra bit so counter+SNOOZE_SEC cannot overflow before the wrap
        sum_s          = {1'b0, counter} + SNOOZE_EXT;
        if (sum_s >= DAY_EXT) begin
            snz_dl_s = CNT_W'(sum_s - DAY_EXT);
        end else begin
            snz_dl_s = sum_s[CNT_W-1:0];
        end

        if (wr) begin
            setpoint_nxt_s = wr_time;
            state_nxt_s    = wr_en ? ARMED : IDLE;
        end else if (ack) begin
            if ((state_r == RINGING) || (state_r == SNOOZED)) begin
                state_nxt_s = ARMED;
            end else begin
                state_nxt_s = state_r;
            end
        end else if (snooze) begin
            if (state_r == RINGING) begin
                state_nxt_s    = SNOOZED;
                deadline_nxt_s = snz_dl_s;
            end else begin
                state_nxt_s = state_r;
            end
        end else if (match_s) begin
            if ((state_r == ARMED) || (state_r == SNOOZED)) begin
                state_nxt_s = RINGING;
            end else begin
                state_nxt_s = state_r;
            end
        end else begin
            state_nxt_s = state_r;
        end
    end

    assign ring_nxt = (state_nxt_s == RINGING);

    // Channel registers; ring is registered alongside the state
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_r    <= IDLE;
            setpoint_r <= '0;
            deadline_r <= '0;
            ring_r     <= 1'b0;
        end else begin
            state_r    <= state_nxt_s;
            setpoint_r <= setpoint_nxt_s;
            deadline_r <= deadline_nxt_s;
            ring_r     <= ring_nxt;
        end
    end

    assign ring = ring_r;

endmodule

// File: rtl/multi_alarm_clock.sv
// ---------------------------------------------------------------------------
// multi_alarm_clock
//  Time-of-day seconds counter with 1 Hz prescaler and NUM_ALARMS alarm
//  channels (enable, ack, snooze).
//  Ports:
//   clock, reset_n                       system clock, async active-low reset
//   set_flag, set_time                   hold/load counter (ignored if >= day)
//   alarm_wr, alarm_idx, alarm_time,
//   alarm_en                             channel write (idx out of range dropped)
//   ack, snooze                          act on all RINGING channels
//   counter_state                        current second of day
//   sec_tick                             pulse coincident with counter advance
//   alarm_state, alarm_any               per-channel ringing flags and their OR
// ---------------------------------------------------------------------------
module multi_alarm_clock
    import clock_pkg::*;
#(
    parameter int CLK_PER_SEC = 2,
    parameter int DAY_SECONDS = DEF_DAY_SECONDS,
    parameter int NUM_ALARMS  = 4,
    parameter int SNOOZE_SEC  = DEF_SNOOZE_SEC,
    parameter int CNT_W       = DEF_CNT_W,
    parameter int IDX_W       = 2
) (
    input  logic                  clock,
    input  logic                  reset_n,
    input  logic                  set_flag,
    input  logic [CNT_W-1:0]      set_time,
    input  logic                  alarm_wr,
    input  logic [IDX_W-1:0]      alarm_idx,
    input  logic [CNT_W-1:0]      alarm_time,
    input  logic                  alarm_en,
    input  logic                  ack,
    input  logic                  snooze,
    output logic [CNT_W-1:0]      counter_state,
    output logic                  sec_tick,
    output logic [NUM_ALARMS-1:0] alarm_state,
    output logic                  alarm_any
);

    localparam int               PRE_W   = (CLK_PER_SEC > 1) ? $clog2(CLK_PER_SEC) : 1;
    localparam logic [PRE_W-1:0] PRE_MAX = PRE_W'(CLK_PER_SEC - 1);
    localparam logic [CNT_W-1:0] DAY_MAX = CNT_W'(DAY_SECONDS - 1);
    localparam logic [CNT_W:0]   DAY_EXT = (CNT_W+1)'(DAY_SECONDS);

    logic [PRE_W-1:0]      presc_r;
    logic [CNT_W-1:0]      counter_r;
    logic                  sec_tick_r;
    logic                  alarm_any_r;
    logic                  tick_s;
    logic [NUM_ALARMS-1:0] wr_vec_s;
    logic [NUM_ALARMS-1:0] ring_nxt_s;

    // Advance request: prescaler at its top value and not being set
    always_comb begin
        if (set_flag) begin
            tick_s = 1'b0;
        end else begin
            tick_s = (presc_r == PRE_MAX);
        end
    end

    // Write decode; an index with no matching channel selects nothing
    always_comb begin
        wr_vec_s = '0;
        for (int i = 0; i < NUM_ALARMS; i++) begin
            wr_vec_s[i] = alarm_wr && (alarm_idx == IDX_W'(i));
        end
    end

    // Prescaler, seconds counter and registered tick
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            presc_r    <= '0;
            counter_r  <= '0;
            sec_tick_r <= 1'b0;
        end else if (set_flag) begin
            presc_r    <= '0;
            sec_tick_r <= 1'b0;
            if ({1'b0, set_time} < DAY_EXT) begin
                counter_r <= set_time;
            end else begin
                counter_r <= counter_r;
            end
        end else if (tick_s) begin
            presc_r    <= '0;
            sec_tick_r <= 1'b1;
            counter_r  <= (counter_r == DAY_MAX) ? '0 : counter_r + CNT_W'(1);
        end else begin
            presc_r    <= presc_r + PRE_W'(1);
            sec_tick_r <= 1'b0;
        end
    end

    // Registered OR of all ringing flags, aligned with alarm_state
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            alarm_any_r <= 1'b0;
        end else begin
            alarm_any_r <= |ring_nxt_s;
        end
    end

    // Channels see the registered tick and the value it produced, so a ring
    // appears one clock after the counter reaches the target and set-loads
    // (which never raise sec_tick) cannot match.
    for (genvar g = 0; g < NUM_ALARMS; g++) begin : g_ch
        alarm_channel #(
            .CNT_W       (CNT_W),
            .DAY_SECONDS (DAY_SECONDS),
            .SNOOZE_SEC  (SNOOZE_SEC)
        ) u_ch (
            .clock    (clock),
            .reset_n  (reset_n),
            .wr       (wr_vec_s[g]),
            .wr_time  (alarm_time),
            .wr_en    (alarm_en),
            .ack      (ack),
            .snooze   (snooze),
            .tick     (sec_tick_r),
            .counter  (counter_r),
            .ring     (alarm_state[g]),
            .ring_nxt (ring_nxt_s[g])
        );
    end

    assign counter_state = counter_r;
    assign sec_tick      = sec_tick_r;
    assign alarm_any     = alarm_any_r;

endmodule

// File: tb/tb_multi_alarm_clock.sv
module tb_multi_alarm_clock;

    logic        clock = 1'b0;
    logic        reset_n;
    logic        set_flag;
    logic [16:0] set_time;
    logic        alarm_wr;
    logic [1:0]  alarm_idx;
    logic [16:0] alarm_time;
    logic        alarm_en;
    logic        ack;
    logic        snooze;
    logic [16:0] counter_state;
    logic        sec_tick;
    logic [3:0]  alarm_state;
    logic        alarm_any;

    int n_vec = 0;
    int n_err = 0;

    multi_alarm_clock #(.CLK_PER_SEC(2)) dut (
        .clock         (clock),
        .reset_n       (reset_n),
        .set_flag      (set_flag),
        .set_time      (set_time),
        .alarm_wr      (alarm_wr),
        .alarm_idx     (alarm_idx),
        .alarm_time    (alarm_time),
        .alarm_en      (alarm_en),
        .ack           (ack),
        .snooze        (snooze),
        .counter_state (counter_state),
        .sec_tick      (sec_tick),
        .alarm_state   (alarm_state),
        .alarm_any     (alarm_any)
    );

    always #5 clock = ~clock;

    task automatic chk_vec(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_vec++;
        if (obs !== exp_v) begin
            n_err++;
            $display("FAIL %s: got %0d, want %0d", tag, obs, exp_v);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge clock);
    endtask

    task automatic do_set(input logic [16:0] v, input int n);
        set_flag = 1'b1;
        set_time = v;
        step(n);
        set_flag = 1'b0;
    endtask

    task automatic wr_alarm(input logic [1:0] idx, input logic [16:0] t, input logic en);
        alarm_idx  = idx;
        alarm_time = t;
        alarm_en   = en;
        alarm_wr   = 1'b1;
        step(1);
        alarm_wr   = 1'b0;
    endtask

    task automatic pulse(input logic a, input logic s);
        ack    = a;
        snooze = s;
        step(1);
        ack    = 1'b0;
        snooze = 1'b0;
    endtask

    // Bounded wait for a counter value; an expired bound shows as a miscompare
    task automatic wait_cnt(input string tag, input logic [16:0] v, input int budget);
        int k = 0;
        while (counter_state !== v && k < budget) begin
            step(1);
            k++;
        end
        chk_vec(tag, {15'd0, counter_state}, {15'd0, v});
    endtask

    initial begin
        reset_n = 1'b0; set_flag = 1'b0; set_time = 17'd0;
        alarm_wr = 1'b0; alarm_idx = 2'd0; alarm_time = 17'd0; alarm_en = 1'b0;
        ack = 1'b0; snooze = 1'b0;

        // reset state
        step(1);
        chk_vec("rst_cnt", {15'd0, counter_state}, 32'd0);
        chk_vec("rst_tick", {31'd0, sec_tick}, 32'd0);
        chk_vec("rst_alarm", {28'd0, alarm_state}, 32'd0);
        chk_vec("rst_any", {31'd0, alarm_any}, 32'd0);
        reset_n = 1'b1;

        // free run: advance every second clock
        for (int j = 1; j <= 11; j++) begin
            step(1);
            chk_vec("run_cnt", {15'd0, counter_state}, j / 2);
            chk_vec("run_tick", {31'd0, sec_tick}, ((j % 2) == 0) ? 32'd1 : 32'd0);
        end

        // out-of-range set is ignored, counter holds
        do_set(17'd90000, 3);
        chk_vec("set_bad_hold", {15'd0, counter_state}, 32'd5);
        chk_vec("set_bad_tick", {31'd0, sec_tick}, 32'd0);

        // valid set held for 10 clocks; arm ch0 meanwhile
        set_flag = 1'b1;
        set_time = 17'd34953;
        wr_alarm(2'd0, 17'd34961, 1'b1);
        step(9);
        chk_vec("set_hold", {15'd0, counter_state}, 32'd34953);
        chk_vec("set_tick0", {31'd0, sec_tick}, 32'd0);
        set_flag = 1'b0;
        step(1);
        chk_vec("rel_1clk", {15'd0, counter_state}, 32'd34953);
        step(1);
        chk_vec("rel_2clk", {15'd0, counter_state}, 32'd34954);
        chk_vec("rel_tick", {31'd0, sec_tick}, 32'd1);

        // ch0 rings one clock after counter reaches 34961
        wait_cnt("wait_34961", 17'd34961, 40);
        chk_vec("ch0_pre", {28'd0, alarm_state}, 32'd0);
        step(1);
        chk_vec("ch0_ring", {28'd0, alarm_state}, 32'b0001);
        chk_vec("ch0_any", {31'd0, alarm_any}, 32'd1);
        step(6);
        chk_vec("ch0_persist", {28'd0, alarm_state}, 32'b0001);
        pulse(1'b1, 1'b0);
        chk_vec("ch0_ack", {28'd0, alarm_state}, 32'd0);
        chk_vec("ch0_ack_any", {31'd0, alarm_any}, 32'd0);
        // still armed: rings again when the time comes round
        do_set(17'd34960, 2);
        wait_cnt("wait_34961b", 17'd34961, 10);
        step(1);
        chk_vec("ch0_again", {28'd0, alarm_state}, 32'b0001);
        pulse(1'b1, 1'b0);

        // set equal to setpoint does not ring; one second earlier does
        wr_alarm(2'd2, 17'd50925, 1'b1);
        do_set(17'd50925, 3);
        wait_cnt("wait_50926", 17'd50926, 10);
        step(2);
        chk_vec("ch2_no_ring", {28'd0, alarm_state}, 32'd0);
        do_set(17'd50924, 2);
        wait_cnt("wait_50925", 17'd50925, 10);
        step(1);
        chk_vec("ch2_ring", {28'd0, alarm_state}, 32'b0100);
        wr_alarm(2'd2, 17'd50925, 1'b0);
        chk_vec("ch2_disable", {28'd0, alarm_state}, 32'd0);

        // ch1 snooze: deadline 50925+540 = 51465
        wr_alarm(2'd1, 17'd50925, 1'b1);
        do_set(17'd50924, 2);
        wait_cnt("wait_50925b", 17'd50925, 10);
        step(1);
        chk_vec("ch1_ring", {28'd0, alarm_state}, 32'b0010);
        pulse(1'b0, 1'b1);
        chk_vec("ch1_snoozed", {28'd0, alarm_state}, 32'd0);
        wait_cnt("wait_51465", 17'd51465, 1200);
        chk_vec("ch1_snz_pre", {28'd0, alarm_state}, 32'd0);
        step(1);
        chk_vec("ch1_snz_ring", {28'd0, alarm_state}, 32'b0010);
        // ack beats snooze: ARMED, no new deadline at 52005
        pulse(1'b1, 1'b1);
        chk_vec("ch1_ack_snz", {28'd0, alarm_state}, 32'd0);
        wait_cnt("wait_52005", 17'd52005, 1200);
        step(1);
        chk_vec("ch1_no_resnz", {28'd0, alarm_state}, 32'd0);
        wr_alarm(2'd1, 17'd50925, 1'b0);

        // day wrap and alarm at second 0
        wr_alarm(2'd3, 17'd0, 1'b1);
        do_set(17'd86399, 2);
        step(1);
        chk_vec("wrap_pre", {15'd0, counter_state}, 32'd86399);
        step(1);
        chk_vec("wrap_cnt", {15'd0, counter_state}, 32'd0);
        chk_vec("wrap_tick", {31'd0, sec_tick}, 32'd1);
        step(1);
        chk_vec("ch3_ring", {28'd0, alarm_state}, 32'b1000);

        // snooze at 86000 wraps deadline to 140
        set_flag = 1'b1;
        set_time = 17'd86000;
        step(2);
        pulse(1'b0, 1'b1);
        set_flag = 1'b0;
        chk_vec("ch3_snoozed", {28'd0, alarm_state}, 32'd0);
        wait_cnt("wait_140", 17'd140, 1200);
        chk_vec("ch3_pre140", {28'd0, alarm_state}, 32'd0);
        step(1);
        chk_vec("ch3_ring140", {28'd0, alarm_state}, 32'b1000);

        // reset mid-ring: immediate return, no residual ring
        reset_n = 1'b0;
        #1;
        chk_vec("mid_rst_alarm", {28'd0, alarm_state}, 32'd0);
        chk_vec("mid_rst_any", {31'd0, alarm_any}, 32'd0);
        chk_vec("mid_rst_cnt", {15'd0, counter_state}, 32'd0);
        step(1);
        reset_n = 1'b1;
        step(4);
        chk_vec("post_rst_cnt", {15'd0, counter_state}, 32'd2);
        chk_vec("post_rst_alarm", {28'd0, alarm_state}, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
